multi_bios_select: RTL and testbench

//  N-way BIOS flash chip-select controller, successor of the dual-socket BIOS select block.

---
 rtl/multi_bios_select.sv | 165 ++++++++++++++++
 tb/tb_multi_bios_select.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_bios_select.sv
// N-way BIOS flash chip-select controller: routes the chipset SPI CS to the active socket,
// rotates images on boot or watchdog swap, and qualifies power-good before allowing swaps.
module multi_bios_select #(
  parameter int         NUM_BIOS        = 2,
  parameter int         SEL_W           = (NUM_BIOS > 2) ? $clog2(NUM_BIOS) : 1,
  parameter logic [4:0] REG_ADDR        = 5'h4,
  parameter int         PG_STABLE_TICKS = 7
) (
  input  logic                  LpcClock,
  input  logic                  ResetN,
  input  logic                  RstBiosFlg,
  input  logic                  MainReset,
  input  logic                  ALL_PWRGD,
  input  logic                  Strobe125ms,
  input  logic                  ForceSwap,
  input  logic                  BIOS_SEL,
  input  logic                  Write,
  input  logic [4:0]            RegAddress,
  input  logic [7:0]            Data,
  input  logic                  BiosCS,
  output logic [NUM_BIOS-1:0]   BIOS,
  output wire  [NUM_BIOS-1:0]   BiosLed,
  output logic                  SwapDisable,
  output logic [4*SEL_W+2:0]    BiosStatus
);

  localparam int               PG_W     = $clog2(PG_STABLE_TICKS + 1);
  localparam logic [PG_W-1:0]  PG_MAX   = PG_W'(PG_STABLE_TICKS);
  localparam logic [SEL_W:0]   FAIL_MAX = (SEL_W+1)'(NUM_BIOS);
  localparam logic [SEL_W:0]   FAIL_PRE = (SEL_W+1)'(NUM_BIOS - 1);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_BIOS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_COMMIT} state_t;

  state_t            state;
  logic              start;
  logic [SEL_W-1:0]  cur_sel, next_sel, act_sel;
  logic [SEL_W:0]    fail_cnt;
  logic              all_failed;
  logic              pg_p0, pg_p1;
  logic [PG_W-1:0]   pg_cnt;
  logic              trig_p0, trig_p1, trig_p2;
  logic              boot, reg_wr;
  logic [SEL_W-1:0]  wr_act, wr_next;
  wire               unused_data = ^Data;

  function automatic logic in_range(input logic [SEL_W-1:0] v);
    return ({1'b0, v} < FAIL_MAX);
  endfunction

  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] v);
    return (v == LAST_IDX) ? '0 : v + 1'b1;
  endfunction

  // power-good synchronizer and stability counter
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      pg_p0  <= 1'b0;
      pg_p1  <= 1'b0;
      pg_cnt <= '0;
    end else begin
      pg_p0 <= ALL_PWRGD;
      pg_p1 <= pg_p0;
      if (!pg_p1)
        pg_cnt <= '0;
      else if (Strobe125ms && pg_cnt != PG_MAX)
        pg_cnt <= pg_cnt + 1'b1;
    end
  end

  assign SwapDisable = (pg_cnt < PG_MAX);

  // boot trigger synchronizer and rising-edge detect
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      trig_p0 <= 1'b0;
      trig_p1 <= 1'b0;
      trig_p2 <= 1'b0;
    end else begin
      trig_p0 <= MainReset | SwapDisable;
      trig_p1 <= trig_p0;
      trig_p2 <= trig_p1;
    end
  end

  assign boot    = trig_p1 & ~trig_p2 & ~SwapDisable;
  assign reg_wr  = Write && (RegAddress == REG_ADDR);
  assign wr_act  = Data[SEL_W-1:0];
  assign wr_next = Data[SEL_W+3:4];

  // swap pipeline, selection registers and failure tracking
  always_ff @(posedge LpcClock or negedge ResetN) begin
    if (!ResetN) begin
      state      <= S_IDLE;
      start      <= 1'b0;
      cur_sel    <= '0;
      next_sel   <= SEL_W'(1);
      act_sel    <= '0;
      fail_cnt   <= '0;
      all_failed <= 1'b0;
    end else if (RstBiosFlg) begin
      state      <= S_IDLE;
      start      <= 1'b0;
      cur_sel    <= '0;
      next_sel   <= SEL_W'(1);
      act_sel    <= '0;
      fail_cnt   <= '0;
      all_failed <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (boot || ForceSwap) begin
            state <= S_START;
            start <= 1'b1;
            if (ForceSwap && fail_cnt != FAIL_MAX) begin
              fail_cnt <= fail_cnt + 1'b1;
              if (fail_cnt == FAIL_PRE)
                all_failed <= 1'b1;
            end
          end
        end
        S_START:  state <= S_COMMIT;
        S_COMMIT: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase

      if (!BIOS_SEL || state == S_START)
        cur_sel <= next_sel;

      if (reg_wr && state != S_COMMIT) begin
        if (in_range(wr_act))
          act_sel <= wr_act;
        if (in_range(wr_next))
          next_sel <= wr_next;
      end

      if (state == S_COMMIT) begin
        if (fail_cnt == FAIL_MAX) begin
          act_sel  <= '0;
          next_sel <= '0;
        end else begin
          act_sel  <= cur_sel;
          next_sel <= next_idx(cur_sel);
        end
      end

      if (reg_wr && Data[7]) begin
        fail_cnt   <= '0;
        all_failed <= 1'b0;
      end
    end
  end

  genvar i;
  generate
    for (i = 0; i < NUM_BIOS; i++) begin : g_sock
      assign BIOS[i]    = (act_sel == SEL_W'(i)) ? BiosCS : 1'b1;
      assign BiosLed[i] = (cur_sel == SEL_W'(i)) ? 1'b0 : 1'bz;
    end
  endgenerate

  assign BiosStatus = {all_failed, start, fail_cnt, cur_sel, next_sel, act_sel};

endmodule

// File: tb/tb_multi_bios_select.sv
// Directed bench for multi_bios_select: a 3-socket and a 4-socket instance share stimulus
// and are compared against hand-computed status words.
module tb_multi_bios_select;
  logic       LpcClock = 1'b0;
  logic       ResetN = 1'b0;
  logic       RstBiosFlg = 1'b0;
  logic       MainReset = 1'b0;
  logic       ALL_PWRGD = 1'b0;
  logic       Strobe125ms = 1'b0;
  logic       ForceSwap = 1'b0;
  logic       BIOS_SEL = 1'b1;
  logic       Write = 1'b0;
  logic [4:0] RegAddress = 5'h0;
  logic [7:0] Data = 8'h0;
  logic       BiosCS = 1'b1;

  logic [2:0]  bios3;
  logic [3:0]  bios4;
  wire  [2:0]  led3;
  wire  [3:0]  led4;
  logic        sd3, sd4;
  logic [10:0] st3, st4;

  int checks = 0;
  int errors = 0;

  always #5 LpcClock = ~LpcClock;

  multi_bios_select #(.NUM_BIOS(3)) u3 (
    .LpcClock(LpcClock), .ResetN(ResetN), .RstBiosFlg(RstBiosFlg), .MainReset(MainReset),
    .ALL_PWRGD(ALL_PWRGD), .Strobe125ms(Strobe125ms), .ForceSwap(ForceSwap), .BIOS_SEL(BIOS_SEL),
    .Write(Write), .RegAddress(RegAddress), .Data(Data), .BiosCS(BiosCS),
    .BIOS(bios3), .BiosLed(led3), .SwapDisable(sd3), .BiosStatus(st3));

  multi_bios_select #(.NUM_BIOS(4)) u4 (
    .LpcClock(LpcClock), .ResetN(ResetN), .RstBiosFlg(RstBiosFlg), .MainReset(MainReset),
    .ALL_PWRGD(ALL_PWRGD), .Strobe125ms(Strobe125ms), .ForceSwap(ForceSwap), .BIOS_SEL(BIOS_SEL),
    .Write(Write), .RegAddress(RegAddress), .Data(Data), .BiosCS(BiosCS),
    .BIOS(bios4), .BiosLed(led4), .SwapDisable(sd4), .BiosStatus(st4));

  // status word: {AllFailed, Start, FailCnt[2:0], Current[1:0], Next[1:0], Active[1:0]}
  function automatic logic [10:0] pk(input logic af, input logic s, input logic [2:0] f,
                                     input logic [1:0] c, input logic [1:0] n, input logic [1:0] a);
    return {af, s, f, c, n, a};
  endfunction

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) @(negedge LpcClock);
  endtask

  task automatic tick();
    @(negedge LpcClock) Strobe125ms = 1'b1;
    @(negedge LpcClock) Strobe125ms = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge LpcClock);
    Write = 1'b1; RegAddress = a; Data = d;
    @(negedge LpcClock);
    Write = 1'b0; Data = 8'h0;
  endtask

  task automatic fswap();
    @(negedge LpcClock) ForceSwap = 1'b1;
    @(negedge LpcClock) ForceSwap = 1'b0;
    cyc(3);
  endtask

  task automatic rstflg();
    @(negedge LpcClock) RstBiosFlg = 1'b1;
    @(negedge LpcClock) RstBiosFlg = 1'b0;
  endtask

  task automatic test_reset();
    BiosCS = 1'b0;
    cyc(1);
    checks++; if (st3 !== pk(0,0,0,0,1,0)) begin errors++; $display("FAIL reset_status3 got %h exp %h", st3, pk(0,0,0,0,1,0)); end
    checks++; if (st4 !== pk(0,0,0,0,1,0)) begin errors++; $display("FAIL reset_status4 got %h exp %h", st4, pk(0,0,0,0,1,0)); end
    checks++; if (sd3 !== 1'b1 || sd4 !== 1'b1) begin errors++; $display("FAIL reset_swapdis got %b%b exp 11", sd3, sd4); end
    checks++; if (bios4 !== 4'b1110) begin errors++; $display("FAIL reset_bios4 got %b exp 1110", bios4); end
    BiosCS = 1'b1;
  endtask

  task automatic test_pg_qualify();
    ALL_PWRGD = 1'b1;
    cyc(4);
    for (int t = 0; t < 6; t++) tick();
    checks++; if (sd3 !== 1'b1) begin errors++; $display("FAIL pg_6ticks got %b exp 1", sd3); end
    tick();
    checks++; if (sd3 !== 1'b0 || sd4 !== 1'b0) begin errors++; $display("FAIL pg_7ticks got %b%b exp 00", sd3, sd4); end
    cyc(5);
    checks++; if (st3 !== pk(0,0,0,0,1,0)) begin errors++; $display("FAIL pg_no_boot got %h exp %h", st3, pk(0,0,0,0,1,0)); end
  endtask

  task automatic test_rst_flag();
    wr(5'h4, 8'h21);
    @(negedge LpcClock);
    RstBiosFlg = 1'b1; Write = 1'b1; RegAddress = 5'h4; Data = 8'h92;
    @(negedge LpcClock);
    RstBiosFlg = 1'b0; Write = 1'b0; Data = 8'h0;
    checks++; if (st4 !== pk(0,0,0,0,1,0)) begin errors++; $display("FAIL rstflg_status got %h exp %h", st4, pk(0,0,0,0,1,0)); end
    checks++; if (sd4 !== 1'b0) begin errors++; $display("FAIL rstflg_keeps_pg got %b exp 0", sd4); end
  endtask

  task automatic test_boot_rotation();
    int starts = 0;
    MainReset = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge LpcClock);
      if (k == 1) MainReset = 1'b0;
      if (st3[9] === 1'b1) starts++;
    end
    checks++; if (starts !== 1) begin errors++; $display("FAIL boot_start_pulse got %0d exp 1", starts); end
    checks++; if (st3 !== pk(0,0,0,1,2,1)) begin errors++; $display("FAIL boot1_status3 got %h exp %h", st3, pk(0,0,0,1,2,1)); end
    checks++; if (st4 !== pk(0,0,0,1,2,1)) begin errors++; $display("FAIL boot1_status4 got %h exp %h", st4, pk(0,0,0,1,2,1)); end
    MainReset = 1'b1;
    cyc(2);
    MainReset = 1'b0;
    cyc(10);
    checks++; if (st3 !== pk(0,0,0,2,0,2)) begin errors++; $display("FAIL boot2_status3 got %h exp %h", st3, pk(0,0,0,2,0,2)); end
    checks++; if (st4 !== pk(0,0,0,2,3,2)) begin errors++; $display("FAIL boot2_status4 got %h exp %h", st4, pk(0,0,0,2,3,2)); end
  endtask

  task automatic test_force_swap_fail();
    fswap();
    checks++; if (st3 !== pk(0,0,1,0,1,0)) begin errors++; $display("FAIL fs1_status3 got %h exp %h", st3, pk(0,0,1,0,1,0)); end
    checks++; if (st4 !== pk(0,0,1,3,0,3)) begin errors++; $display("FAIL fs1_status4 got %h exp %h", st4, pk(0,0,1,3,0,3)); end
    fswap();
    checks++; if (st3 !== pk(0,0,2,1,2,1)) begin errors++; $display("FAIL fs2_status3 got %h exp %h", st3, pk(0,0,2,1,2,1)); end
    fswap();
    checks++; if (st3 !== pk(1,0,3,2,0,0)) begin errors++; $display("FAIL fs3_status3 got %h exp %h", st3, pk(1,0,3,2,0,0)); end
    checks++; if (st4 !== pk(0,0,3,1,2,1)) begin errors++; $display("FAIL fs3_status4 got %h exp %h", st4, pk(0,0,3,1,2,1)); end
    fswap();
    checks++; if (st3 !== pk(1,0,3,0,0,0)) begin errors++; $display("FAIL fs4_sat3 got %h exp %h", st3, pk(1,0,3,0,0,0)); end
    checks++; if (st4 !== pk(1,0,4,2,0,0)) begin errors++; $display("FAIL fs4_status4 got %h exp %h", st4, pk(1,0,4,2,0,0)); end
    wr(5'h4, 8'h80);
    checks++; if (st3 !== pk(0,0,0,0,0,0)) begin errors++; $display("FAIL clear_status3 got %h exp %h", st3, pk(0,0,0,0,0,0)); end
    checks++; if (st4 !== pk(0,0,0,2,0,0)) begin errors++; $display("FAIL clear_status4 got %h exp %h", st4, pk(0,0,0,2,0,0)); end
  endtask

  task automatic test_register_write();
    rstflg();
    wr(5'h4, 8'h21);
    checks++; if (st4 !== pk(0,0,0,0,2,1)) begin errors++; $display("FAIL wr21_status4 got %h exp %h", st4, pk(0,0,0,0,2,1)); end
    BiosCS = 1'b0;
    #1;
    checks++; if (bios4 !== 4'b1101) begin errors++; $display("FAIL route_bios4 got %b exp 1101", bios4); end
    checks++; if (bios3 !== 3'b101) begin errors++; $display("FAIL route_bios3 got %b exp 101", bios3); end
    BiosCS = 1'b1;
    #1;
    checks++; if (bios4 !== 4'b1111) begin errors++; $display("FAIL idle_bios4 got %b exp 1111", bios4); end
    wr(5'h4, 8'h31);
    checks++; if (st3 !== pk(0,0,0,0,2,1)) begin errors++; $display("FAIL wr31_status3 got %h exp %h", st3, pk(0,0,0,0,2,1)); end
    checks++; if (st4 !== pk(0,0,0,0,3,1)) begin errors++; $display("FAIL wr31_status4 got %h exp %h", st4, pk(0,0,0,0,3,1)); end
    wr(5'h4, 8'h03);
    checks++; if (st3 !== pk(0,0,0,0,0,1)) begin errors++; $display("FAIL wr03_status3 got %h exp %h", st3, pk(0,0,0,0,0,1)); end
    checks++; if (st4 !== pk(0,0,0,0,0,3)) begin errors++; $display("FAIL wr03_status4 got %h exp %h", st4, pk(0,0,0,0,0,3)); end
    wr(5'h5, 8'h11);
    checks++; if (st4 !== pk(0,0,0,0,0,3)) begin errors++; $display("FAIL wr_badaddr got %h exp %h", st4, pk(0,0,0,0,0,3)); end
  endtask

  task automatic test_write_commit();
    rstflg();
    @(negedge LpcClock) ForceSwap = 1'b1;
    @(negedge LpcClock) ForceSwap = 1'b0;
    @(negedge LpcClock);
    Write = 1'b1; RegAddress = 5'h4; Data = 8'h83;
    @(negedge LpcClock);
    Write = 1'b0; Data = 8'h0;
    checks++; if (st4 !== pk(0,0,0,1,2,1)) begin errors++; $display("FAIL wr_commit4 got %h exp %h", st4, pk(0,0,0,1,2,1)); end
    checks++; if (st3 !== pk(0,0,0,1,2,1)) begin errors++; $display("FAIL wr_commit3 got %h exp %h", st3, pk(0,0,0,1,2,1)); end
  endtask

  task automatic test_bios_sel();
    rstflg();
    BIOS_SEL = 1'b0;
    cyc(2);
    checks++; if (st3 !== pk(0,0,0,1,1,0)) begin errors++; $display("FAIL biossel_track got %h exp %h", st3, pk(0,0,0,1,1,0)); end
    wr(5'h4, 8'h20);
    cyc(1);
    checks++; if (st4 !== pk(0,0,0,2,2,0)) begin errors++; $display("FAIL biossel_follow got %h exp %h", st4, pk(0,0,0,2,2,0)); end
    checks++; if (led3[2] !== 1'b0) begin errors++; $display("FAIL led_current got %b exp 0", led3[2]); end
    BIOS_SEL = 1'b1;
  endtask

  task automatic test_pg_drop();
    ALL_PWRGD = 1'b0;
    cyc(4);
    checks++; if (sd3 !== 1'b1) begin errors++; $display("FAIL pgdrop_disable got %b exp 1", sd3); end
    ALL_PWRGD = 1'b1;
    cyc(3);
    for (int t = 0; t < 3; t++) tick();
    ALL_PWRGD = 1'b0;
    cyc(4);
    ALL_PWRGD = 1'b1;
    cyc(3);
    for (int t = 0; t < 6; t++) tick();
    checks++; if (sd4 !== 1'b1) begin errors++; $display("FAIL pgdrop_cleared got %b exp 1", sd4); end
    tick();
    checks++; if (sd4 !== 1'b0) begin errors++; $display("FAIL pgdrop_requal got %b exp 0", sd4); end
    cyc(5);
    checks++; if (st4 !== pk(0,0,0,2,2,0)) begin errors++; $display("FAIL pgdrop_no_boot got %h exp %h", st4, pk(0,0,0,2,2,0)); end
  endtask

  task automatic test_swap_during_commit();
    rstflg();
    @(negedge LpcClock) ForceSwap = 1'b1;
    @(negedge LpcClock) ForceSwap = 1'b0;
    @(negedge LpcClock) ForceSwap = 1'b1;
    @(negedge LpcClock) ForceSwap = 1'b0;
    cyc(3);
    checks++; if (st3 !== pk(0,0,1,1,2,1)) begin errors++; $display("FAIL commit_drop3 got %h exp %h", st3, pk(0,0,1,1,2,1)); end
    checks++; if (st4 !== pk(0,0,1,1,2,1)) begin errors++; $display("FAIL commit_drop4 got %h exp %h", st4, pk(0,0,1,1,2,1)); end
  endtask

  task automatic test_reset_during_start();
    BiosCS = 1'b0;
    @(negedge LpcClock) ForceSwap = 1'b1;
    @(negedge LpcClock) ForceSwap = 1'b0;
    checks++; if (st4[9] !== 1'b1) begin errors++; $display("FAIL start_seen got %b exp 1", st4[9]); end
    #2 ResetN = 1'b0;
    #1;
    checks++; if (st3 !== pk(0,0,0,0,1,0)) begin errors++; $display("FAIL rst_start3 got %h exp %h", st3, pk(0,0,0,0,1,0)); end
    checks++; if (st4 !== pk(0,0,0,0,1,0)) begin errors++; $display("FAIL rst_start4 got %h exp %h", st4, pk(0,0,0,0,1,0)); end
    checks++; if (sd4 !== 1'b1) begin errors++; $display("FAIL rst_swapdis got %b exp 1", sd4); end
    checks++; if (bios3 !== 3'b110) begin errors++; $display("FAIL rst_bios3 got %b exp 110", bios3); end
    checks++; if (led4[0] !== 1'b0 || led3[0] !== 1'b0) begin errors++; $display("FAIL rst_led0 got %b%b exp 00", led4[0], led3[0]); end
    @(negedge LpcClock) ResetN = 1'b1;
    BiosCS = 1'b1;
  endtask

  initial begin
    cyc(3);
    ResetN = 1'b1;
    test_reset();
    test_pg_qualify();
    test_rst_flag();
    test_boot_rotation();
    test_force_swap_fail();
    test_register_write();
    test_write_commit();
    test_bios_sel();
    test_pg_drop();
    test_swap_during_commit();
    test_reset_during_start();
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
